// File: rtl/vx_tcu_tfr_pipe_drain_pkg.sv
// rtl/vx_tcu_tfr_pipe_drain_pkg.sv - shared helpers for the TFR pipe drain
//
// Purpose: sizing helpers shared by the drain top and its result FIFO.
// The {valid, lane_mask} token struct is declared in the top module.
// Its width depends on the NUM_LANES parameter, and token_width() gives
// that width for any code that needs it outside the top.
// Ports: none (package).

package vx_tcu_tfr_pipe_drain_pkg;

  // Width of a counter that must represent 0..fifo_size inclusive.
  function automatic int credit_width(input int fifo_size);
    return $clog2(fifo_size + 1);
  endfunction

  // Bits in one shadow token: one valid bit plus the lane mask.
  function automatic int token_width(input int num_lanes);
    return num_lanes + 1;
  endfunction

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int ptr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/vx_tcu_tfr_result_fifo.sv
// rtl/vx_tcu_tfr_result_fifo.sv - skid FIFO capturing the driven chain output
//
// Purpose: SIZE-entry FIFO with simultaneous push/pop at any occupancy.
// The head entry is read from registered storage, so an entry pushed into an
// empty FIFO is presented the cycle after the push.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, push_data   write request and data
//   pop               read request (ignored while empty)
//   head_data         oldest entry (meaningful only while !empty)
//   empty, full       occupancy flags

module vx_tcu_tfr_result_fifo
  import vx_tcu_tfr_pipe_drain_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_width(SIZE);
  localparam int CW = credit_width(SIZE);

  logic [WIDTH-1:0] mem [SIZE];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  // Pointers wrap at SIZE, not at a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(SIZE));
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage carries no reset; the head is qualified by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Credits upstream make this impossible; trip loudly if that ever breaks.
  assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !do_pop))
    else $error("result fifo overflow");

endmodule

// File: rtl/vx_tcu_tfr_pipe_drain.sv
// rtl/vx_tcu_tfr_pipe_drain.sv - valid/credit flow control for a TFR pipe chain
//
// Purpose: receiving end of a fixed-latency, enable-gated pipe chain that has
// no valid bit and no backpressure. A shadow shift register tracks in-flight
// tokens. The chain output is captured into a skid FIFO, and issue credits
// guarantee that FIFO space is always available.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid, in_lane_mask, in_ready  issue handshake (credit-based ready)
//   pipe_enable, pipe_lane_mask       controls for the driven chain
//   pipe_shared_out, pipe_lane_out    chain outputs
//   out_valid, out_ready              result handshake
//   out_shared, out_lane_data,
//   out_lane_mask                     result payload (zero while empty)

module vx_tcu_tfr_pipe_drain
  import vx_tcu_tfr_pipe_drain_pkg::*;
#(
  parameter int SHARED_DATAW   = 1,
  parameter int LANE_DATAW     = 1,
  parameter int NUM_LANES      = 1,
  parameter int DEPTH          = 1,
  parameter int FIFO_SIZE      = DEPTH + 2,
  parameter int PER_LANE_VALID = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic [NUM_LANES-1:0]            in_lane_mask,
  output logic                            in_ready,
  output logic                            pipe_enable,
  output logic [NUM_LANES-1:0]            pipe_lane_mask,
  input  logic [SHARED_DATAW-1:0]         pipe_shared_out,
  input  logic [NUM_LANES*LANE_DATAW-1:0] pipe_lane_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SHARED_DATAW-1:0]         out_shared,
  output logic [NUM_LANES*LANE_DATAW-1:0] out_lane_data,
  output logic [NUM_LANES-1:0]            out_lane_mask
);

  localparam int CW  = credit_width(FIFO_SIZE);
  localparam int LDW = NUM_LANES * LANE_DATAW;
  localparam int FW  = SHARED_DATAW + LDW + NUM_LANES;

  if (DEPTH < 1) begin : g_bad_depth
    $error("vx_tcu_tfr_pipe_drain: DEPTH must be >= 1");
  end
  if (FIFO_SIZE < 1) begin : g_bad_fifo
    $error("vx_tcu_tfr_pipe_drain: FIFO_SIZE must be >= 1");
  end

  typedef struct packed {
    logic                 valid;
    logic [NUM_LANES-1:0] lane_mask;
  } token_t;

  token_t           shadow [DEPTH];
  logic [CW-1:0]    credits;
  logic             in_fire;
  logic             out_fire;
  logic             any_inflight;
  logic             capture;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FW-1:0]    fifo_head;
  logic [SHARED_DATAW-1:0] head_shared;
  logic [LDW-1:0]          head_lanes;
  logic [NUM_LANES-1:0]    head_mask;

  always_comb begin
    any_inflight = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_inflight = any_inflight | shadow[i].valid;
    end
  end

  // Counter covers in-flight tokens plus FIFO occupancy, so an accepted token
  // always has a FIFO slot waiting when it leaves the chain.
  assign in_ready = (credits < CW'(FIFO_SIZE));
  // Nothing is accepted while reset is held, which also keeps the chain frozen.
  assign in_fire        = reset_n & in_valid & in_ready;
  assign pipe_enable    = in_fire | any_inflight;
  assign pipe_lane_mask = '1;
  assign capture        = pipe_enable & shadow[DEPTH-1].valid;
  assign out_valid      = ~fifo_empty;
  assign out_fire       = out_valid & out_ready;

  // Shifts in lockstep with the chain, bubbles included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
      end
    end else if (pipe_enable) begin
      shadow[0] <= '{valid: in_fire, lane_mask: in_lane_mask};
      for (int i = 1; i < DEPTH; i++) begin
        shadow[i] <= shadow[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  vx_tcu_tfr_result_fifo #(
    .WIDTH (FW),
    .SIZE  (FIFO_SIZE)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data ({pipe_shared_out, pipe_lane_out, shadow[DEPTH-1].lane_mask}),
    .pop       (out_fire),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_shared = fifo_head[FW-1 -: SHARED_DATAW];
  assign head_lanes  = fifo_head[NUM_LANES +: LDW];
  assign head_mask   = fifo_head[NUM_LANES-1:0];

  always_comb begin
    out_shared    = '0;
    out_lane_data = '0;
    out_lane_mask = '0;
    if (!fifo_empty) begin
      out_shared    = head_shared;
      out_lane_mask = head_mask;
      for (int i = 0; i < NUM_LANES; i++) begin
        if ((PER_LANE_VALID != 0) && !head_mask[i]) begin
          out_lane_data[i*LANE_DATAW +: LANE_DATAW] = '0;
        end else begin
          out_lane_data[i*LANE_DATAW +: LANE_DATAW] = head_lanes[i*LANE_DATAW +: LANE_DATAW];
        end
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
